// File: rtl/jtag_driver.sv
// rtl/jtag_driver.sv - JTAG initiator turning shift commands into TCK/TMS/TDI waveforms
module jtag_driver #(
  parameter int DATA_W = 40,
  parameter int LEN_W  = 6,
  parameter int DIV    = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              jtag_pin_TCK,
  output logic              jtag_pin_TMS,
  output logic              jtag_pin_TDI,
  input  logic              jtag_pin_TDO
);

  // Bit index must hold preamble + DATA_W + postamble and also the raw cmd_len
  localparam int BW = $clog2(DATA_W + 7);
  localparam int IW = ((LEN_W > BW) ? LEN_W : BW) + 1;
  localparam int SW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [DW-1:0]     div_cnt;
  logic [IW-1:0]     bit_idx;
  logic [IW-1:0]     last_idx;
  logic [IW-1:0]     shift_len;
  logic [IW-1:0]     pre_len;
  logic              is_reset;
  logic [DATA_W-1:0] data_r;
  logic [DATA_W-1:0] cap_r;
  logic              tck;
  logic              tms;
  logic              tdi;

  logic [IW-1:0]     cmd_len_eff;
  logic [IW-1:0]     nxt_idx;
  logic [IW-1:0]     nxt_off;
  logic [SW-1:0]     nxt_sel;
  logic [SW-1:0]     cur_sel;
  logic              cur_in_shift;
  logic              nxt_tms;
  logic              nxt_tdi;
  logic              phase_end;

  // Length 0 means one bit; anything beyond the data width is clamped
  always_comb begin
    cmd_len_eff = IW'(cmd_len);
    if (cmd_len == '0)
      cmd_len_eff = IW'(1);
    else if (IW'(cmd_len) > IW'(DATA_W))
      cmd_len_eff = IW'(DATA_W);
  end

  // TMS/TDI for the next TCK bit, derived from its position in preamble/shift/postamble
  always_comb begin
    nxt_idx      = bit_idx + IW'(1);
    nxt_off      = nxt_idx - pre_len;
    nxt_sel      = nxt_off[SW-1:0];
    cur_sel      = SW'(bit_idx - pre_len);
    cur_in_shift = !is_reset && (bit_idx >= pre_len) && (bit_idx < pre_len + shift_len);
    phase_end    = (div_cnt == DW'(DIV - 1));
    nxt_tms      = 1'b0;
    nxt_tdi      = 1'b0;
    if (is_reset) begin
      nxt_tms = (nxt_idx < IW'(5));
    end else if (nxt_idx < pre_len) begin
      // IR preamble is 1,1,0,0 and DR preamble is 1,0,0: the leading ones end two bits early
      nxt_tms = (nxt_idx < pre_len - IW'(2));
    end else if (nxt_off < shift_len) begin
      nxt_tms = (nxt_off == shift_len - IW'(1));
      nxt_tdi = data_r[nxt_sel];
    end else begin
      nxt_tms = (nxt_off == shift_len);
    end
  end

  // Command FSM with TCK divider; pins change at falling edges, TDO captured at rising edges
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      div_cnt   <= '0;
      bit_idx   <= '0;
      last_idx  <= '0;
      shift_len <= '0;
      pre_len   <= '0;
      is_reset  <= 1'b0;
      data_r    <= '0;
      cap_r     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == IDLE) begin
        if (cmd_valid && cmd_ready) begin
          state     <= RUN;
          cmd_ready <= 1'b0;
          div_cnt   <= '0;
          bit_idx   <= '0;
          data_r    <= cmd_data;
          cap_r     <= '0;
          tck       <= 1'b0;
          tms       <= 1'b1;
          tdi       <= 1'b0;
          if (cmd_op == 2'd1) begin
            is_reset  <= 1'b0;
            pre_len   <= IW'(4);
            shift_len <= cmd_len_eff;
            last_idx  <= cmd_len_eff + IW'(5);
          end else if (cmd_op == 2'd2) begin
            is_reset  <= 1'b0;
            pre_len   <= IW'(3);
            shift_len <= cmd_len_eff;
            last_idx  <= cmd_len_eff + IW'(4);
          end else begin
            is_reset  <= 1'b1;
            pre_len   <= '0;
            shift_len <= '0;
            last_idx  <= IW'(5);
          end
        end
      end else begin
        if (!phase_end) begin
          div_cnt <= div_cnt + DW'(1);
        end else begin
          div_cnt <= '0;
          if (!tck) begin
            tck <= 1'b1;
            if (cur_in_shift)
              cap_r[cur_sel] <= jtag_pin_TDO;
          end else begin
            tck <= 1'b0;
            if (bit_idx == last_idx) begin
              state     <= IDLE;
              cmd_ready <= 1'b1;
              rsp_valid <= 1'b1;
              rsp_data  <= cap_r;
              tms       <= 1'b0;
              tdi       <= 1'b0;
            end else begin
              bit_idx <= nxt_idx;
              tms     <= nxt_tms;
              tdi     <= nxt_tdi;
            end
          end
        end
      end
    end
  end

  assign busy         = ~cmd_ready;
  assign jtag_pin_TCK = tck;
  assign jtag_pin_TMS = tms;
  assign jtag_pin_TDI = tdi;

endmodule

// File: tb/tb_jtag_driver.sv
// tb/tb_jtag_driver.sv - self-checking bench for jtag_driver against a TAP bit-sequence model
`timescale 1ns/1ps
module tb_jtag_driver;
  localparam int DATA_W = 40;
  localparam int LEN_W  = 6;
  localparam int DIV0   = 2;
  localparam int DIV1   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  logic [1:0] cmd_valid;
  logic [1:0] tdo_rnd;
  logic [1:0] cmd_op [2];
  logic [LEN_W-1:0] cmd_len [2];
  logic [DATA_W-1:0] cmd_data [2];
  logic [1:0] tdo_mode [2];

  logic cmd_ready0, rsp_valid0, busy0, tck0, tms0, tdi0, tdo0;
  logic cmd_ready1, rsp_valid1, busy1, tck1, tms1, tdi1, tdo1;
  logic [DATA_W-1:0] rsp_data0, rsp_data1;

  logic [1:0] cmd_ready_a, rsp_valid_a, busy_a, tck_a, tms_a, tdi_a, tdo_a;
  assign cmd_ready_a = {cmd_ready1, cmd_ready0};
  assign rsp_valid_a = {rsp_valid1, rsp_valid0};
  assign busy_a      = {busy1, busy0};
  assign tck_a       = {tck1, tck0};
  assign tms_a       = {tms1, tms0};
  assign tdi_a       = {tdi1, tdi0};
  assign tdo_a       = {tdo1, tdo0};

  // mode 0: TDO=0, 1: TDO=1, 2: loopback from TDI, 3: random bits
  assign tdo0 = (tdo_mode[0] == 2'd2) ? tdi0 : (tdo_mode[0] == 2'd3) ? tdo_rnd[0] : tdo_mode[0][0];
  assign tdo1 = (tdo_mode[1] == 2'd2) ? tdi1 : (tdo_mode[1] == 2'd3) ? tdo_rnd[1] : tdo_mode[1][0];

  jtag_driver #(.DATA_W(DATA_W), .LEN_W(LEN_W), .DIV(DIV0)) u_dut0 (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready0),
    .cmd_op(cmd_op[0]), .cmd_len(cmd_len[0]), .cmd_data(cmd_data[0]),
    .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .busy(busy0),
    .jtag_pin_TCK(tck0), .jtag_pin_TMS(tms0), .jtag_pin_TDI(tdi0), .jtag_pin_TDO(tdo0));

  jtag_driver #(.DATA_W(DATA_W), .LEN_W(LEN_W), .DIV(DIV1)) u_dut1 (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready1),
    .cmd_op(cmd_op[1]), .cmd_len(cmd_len[1]), .cmd_data(cmd_data[1]),
    .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .busy(busy1),
    .jtag_pin_TCK(tck1), .jtag_pin_TMS(tms1), .jtag_pin_TDI(tdi1), .jtag_pin_TDO(tdo1));

  int checks = 0;
  int passed = 0;

  bit exp_tms[$];
  bit exp_tdi[$];
  int exp_pre, exp_len;

  int m_lat, m_tck_err, m_tms_err, m_tdi_err, m_rdy_err, m_rises;
  bit m_end_ok;
  logic [DATA_W-1:0] m_exp_rsp;

  function automatic logic [DATA_W-1:0] get_rsp(input int s);
    return (s == 0) ? rsp_data0 : rsp_data1;
  endfunction

  function automatic int div_of(input int s);
    return (s == 0) ? DIV0 : DIV1;
  endfunction

  // Reference TMS/TDI bit list for one command, straight from the TAP walk
  task automatic build_exp(input logic [1:0] op, input int len, input logic [DATA_W-1:0] data);
    int l;
    exp_tms.delete();
    exp_tdi.delete();
    l = (len == 0) ? 1 : ((len > DATA_W) ? DATA_W : len);
    if (op == 2'd1 || op == 2'd2) begin
      exp_tms.push_back(1'b1);
      if (op == 2'd1) exp_tms.push_back(1'b1);
      exp_tms.push_back(1'b0);
      exp_tms.push_back(1'b0);
      exp_pre = exp_tms.size();
      exp_len = l;
      for (int i = 0; i < exp_pre; i++) exp_tdi.push_back(1'b0);
      for (int i = 0; i < l; i++) begin
        exp_tms.push_back(i == l - 1);
        exp_tdi.push_back(data[i]);
      end
      exp_tms.push_back(1'b1); exp_tms.push_back(1'b0);
      exp_tdi.push_back(1'b0); exp_tdi.push_back(1'b0);
    end else begin
      for (int i = 0; i < 5; i++) begin exp_tms.push_back(1'b1); exp_tdi.push_back(1'b0); end
      exp_tms.push_back(1'b0); exp_tdi.push_back(1'b0);
      exp_pre = 0;
      exp_len = 0;
    end
  endtask

  task automatic present(input int s, input logic [1:0] op, input int len, input logic [DATA_W-1:0] data);
    cmd_op[s]    = op;
    cmd_len[s]   = LEN_W'(len);
    cmd_data[s]  = data;
    cmd_valid[s] = 1'b1;
  endtask

  // Follows one command from its handshake edge to rsp_valid, tallying waveform deviations
  task automatic watch(input int s, input bit keep_valid, input logic [1:0] nop,
                       input int nlen, input logic [DATA_W-1:0] ndata);
    int n, k, dv;
    bit prev_tck;
    dv = div_of(s);
    n = exp_tms.size();
    m_lat = -1; m_tck_err = 0; m_tms_err = 0; m_tdi_err = 0; m_rdy_err = 0; m_rises = 0;
    m_end_ok = 1'b0; m_exp_rsp = '0; prev_tck = 1'b0;
    @(posedge clk);
    for (int c = 0; c <= 2 * dv * (DATA_W + 8); c++) begin
      @(negedge clk);
      if (c == 0) begin
        if (keep_valid) begin
          cmd_op[s] = nop; cmd_len[s] = LEN_W'(nlen); cmd_data[s] = ndata;
        end else begin
          cmd_valid[s] = 1'b0;
        end
      end
      if (rsp_valid_a[s]) begin
        m_lat = c;
        m_end_ok = (tck_a[s] === 1'b0) && (tms_a[s] === 1'b0) && (tdi_a[s] === 1'b0) &&
                   (cmd_ready_a[s] === 1'b1) && (busy_a[s] === 1'b0);
        break;
      end
      k = c / (2 * dv);
      if (k < n) begin
        if (tck_a[s] !== ((c / dv) % 2 == 1)) m_tck_err++;
        if (tms_a[s] !== exp_tms[k]) m_tms_err++;
        if (tdi_a[s] !== exp_tdi[k]) m_tdi_err++;
      end
      if (cmd_ready_a[s] !== 1'b0 || busy_a[s] !== 1'b1) m_rdy_err++;
      if (tck_a[s] && !prev_tck) begin
        m_rises++;
        if (k >= exp_pre && k < exp_pre + exp_len) m_exp_rsp[k - exp_pre] = tdo_a[s];
      end
      if (!tck_a[s]) tdo_rnd[s] = 1'($urandom);
      prev_tck = tck_a[s];
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({cmd_ready0, busy0, rsp_valid0, tck0, tms0, tdi0} !== 6'b100010)
      $display("FAIL reset_pins0: got %b want 100010", {cmd_ready0, busy0, rsp_valid0, tck0, tms0, tdi0}); else passed++;
    checks++; if ({cmd_ready1, busy1, rsp_valid1, tck1, tms1, tdi1} !== 6'b100010)
      $display("FAIL reset_pins1: got %b want 100010", {cmd_ready1, busy1, rsp_valid1, tck1, tms1, tdi1}); else passed++;
    checks++; if (rsp_data0 !== '0) $display("FAIL reset_rsp_data: got %h want 0", rsp_data0); else passed++;
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({cmd_ready0, busy0, tck0, tms0} !== 4'b1001)
      $display("FAIL post_reset_idle: got %b want 1001", {cmd_ready0, busy0, tck0, tms0}); else passed++;
  endtask

  task automatic test_reset_cmd;
    tdo_mode[0] = 2'd3;
    build_exp(2'd0, 0, '0);
    present(0, 2'd0, 0, '0);
    watch(0, 1'b0, 2'd0, 0, '0);
    checks++; if (m_lat !== 24) $display("FAIL reset_cmd_latency: got %0d want 24", m_lat); else passed++;
    checks++; if (m_rises !== 6) $display("FAIL reset_cmd_tck_pulses: got %0d want 6", m_rises); else passed++;
    checks++; if (m_tms_err + m_tck_err + m_tdi_err !== 0)
      $display("FAIL reset_cmd_wave: got %0d/%0d/%0d errors want 0", m_tms_err, m_tck_err, m_tdi_err); else passed++;
    checks++; if (rsp_data0 !== '0) $display("FAIL reset_cmd_rsp: got %h want 0", rsp_data0); else passed++;
    checks++; if (m_end_ok !== 1'b1) $display("FAIL reset_cmd_end_pins: got %b want 1", m_end_ok); else passed++;
  endtask

  task automatic test_shift_dr;
    tdo_mode[0] = 2'd2;
    build_exp(2'd2, 8, 40'hA5);
    present(0, 2'd2, 8, 40'hA5);
    watch(0, 1'b0, 2'd0, 0, '0);
    checks++; if (m_lat !== 52) $display("FAIL dr8_latency: got %0d want 52", m_lat); else passed++;
    checks++; if (m_rises !== 13) $display("FAIL dr8_tck_pulses: got %0d want 13", m_rises); else passed++;
    checks++; if (m_tms_err + m_tdi_err + m_tck_err + m_rdy_err !== 0)
      $display("FAIL dr8_wave: got %0d/%0d/%0d/%0d errors want 0", m_tms_err, m_tdi_err, m_tck_err, m_rdy_err); else passed++;
    checks++; if (rsp_data0 !== 40'hA5) $display("FAIL dr8_rsp: got %h want a5", rsp_data0); else passed++;
  endtask

  task automatic test_shift_ir;
    tdo_mode[0] = 2'd1;
    build_exp(2'd1, 5, 40'h11);
    present(0, 2'd1, 5, 40'h11);
    watch(0, 1'b0, 2'd0, 0, '0);
    checks++; if (m_lat !== 44) $display("FAIL ir5_latency: got %0d want 44", m_lat); else passed++;
    checks++; if (m_rises !== 11) $display("FAIL ir5_tck_pulses: got %0d want 11", m_rises); else passed++;
    checks++; if (m_tms_err + m_tdi_err !== 0)
      $display("FAIL ir5_wave: got %0d/%0d errors want 0", m_tms_err, m_tdi_err); else passed++;
    checks++; if (rsp_data0 !== 40'h1F) $display("FAIL ir5_rsp: got %h want 1f", rsp_data0); else passed++;
  endtask

  task automatic test_long_dr;
    tdo_mode[1] = 2'd2;
    build_exp(2'd2, 40, 40'h12_3456_789A);
    present(1, 2'd2, 40, 40'h12_3456_789A);
    watch(1, 1'b0, 2'd0, 0, '0);
    checks++; if (m_lat !== 90) $display("FAIL dr40_latency: got %0d want 90", m_lat); else passed++;
    checks++; if (m_rises !== 45) $display("FAIL dr40_tck_pulses: got %0d want 45", m_rises); else passed++;
    checks++; if (m_tck_err + m_tms_err + m_tdi_err !== 0)
      $display("FAIL dr40_wave: got %0d/%0d/%0d errors want 0", m_tck_err, m_tms_err, m_tdi_err); else passed++;
    checks++; if (rsp_data1 !== 40'h12_3456_789A) $display("FAIL dr40_rsp: got %h want 123456789a", rsp_data1); else passed++;
  endtask

  task automatic test_len_edges;
    logic [DATA_W-1:0] d;
    tdo_mode[0] = 2'd3;
    d = DATA_W'({$urandom, $urandom});
    build_exp(2'd2, 0, d);
    present(0, 2'd2, 0, d);
    watch(0, 1'b0, 2'd0, 0, '0);
    checks++; if (m_lat !== 24) $display("FAIL len0_latency: got %0d want 24", m_lat); else passed++;
    checks++; if (rsp_data0 !== m_exp_rsp) $display("FAIL len0_rsp: got %h want %h", rsp_data0, m_exp_rsp); else passed++;
    tdo_mode[1] = 2'd3;
    d = DATA_W'({$urandom, $urandom});
    build_exp(2'd1, 63, d);
    present(1, 2'd1, 63, d);
    watch(1, 1'b0, 2'd0, 0, '0);
    checks++; if (m_lat !== 92) $display("FAIL len63_latency: got %0d want 92", m_lat); else passed++;
    checks++; if (m_tms_err + m_tdi_err !== 0)
      $display("FAIL len63_wave: got %0d/%0d errors want 0", m_tms_err, m_tdi_err); else passed++;
    checks++; if (rsp_data1 !== m_exp_rsp) $display("FAIL len63_rsp: got %h want %h", rsp_data1, m_exp_rsp); else passed++;
  endtask

  task automatic test_random;
    int s, len;
    logic [1:0] op;
    logic [DATA_W-1:0] d;
    for (int it = 0; it < 8; it++) begin
      s   = int'($urandom_range(1, 0));
      op  = 2'($urandom_range(3, 0));
      len = int'($urandom_range(63, 0));
      d   = DATA_W'({$urandom, $urandom});
      tdo_mode[s] = 2'($urandom_range(3, 0));
      build_exp(op, len, d);
      present(s, op, len, d);
      watch(s, 1'b0, 2'd0, 0, '0);
      checks++; if (m_lat !== 2 * div_of(s) * exp_tms.size())
        $display("FAIL rand%0d_latency: got %0d want %0d", it, m_lat, 2 * div_of(s) * exp_tms.size()); else passed++;
      checks++; if (m_tck_err + m_tms_err + m_tdi_err + m_rdy_err !== 0 || m_end_ok !== 1'b1)
        $display("FAIL rand%0d_wave: got %0d/%0d/%0d/%0d errors end %b want 0 end 1", it,
                 m_tck_err, m_tms_err, m_tdi_err, m_rdy_err, m_end_ok); else passed++;
      checks++; if (get_rsp(s) !== m_exp_rsp)
        $display("FAIL rand%0d_rsp: got %h want %h", it, get_rsp(s), m_exp_rsp); else passed++;
    end
  endtask

  task automatic test_back_to_back;
    logic [DATA_W-1:0] da, db;
    da = DATA_W'({$urandom, $urandom});
    db = DATA_W'({$urandom, $urandom});
    tdo_mode[0] = 2'd2;
    build_exp(2'd2, 6, da);
    present(0, 2'd2, 6, da);
    watch(0, 1'b1, 2'd1, 3, db);
    checks++; if (m_lat !== 44 || m_rdy_err !== 0 || m_tms_err + m_tdi_err + m_tck_err !== 0)
      $display("FAIL b2b_first: got lat %0d rdy_err %0d wave_err %0d want 44 0 0", m_lat, m_rdy_err,
               m_tms_err + m_tdi_err + m_tck_err); else passed++;
    checks++; if (m_end_ok !== 1'b1 || cmd_valid[0] !== 1'b1)
      $display("FAIL b2b_ready_on_rsp: got end %b valid %b want 1 1", m_end_ok, cmd_valid[0]); else passed++;
    checks++; if (rsp_data0 !== (da & 40'h3F)) $display("FAIL b2b_rsp_first: got %h want %h", rsp_data0, da & 40'h3F); else passed++;
    build_exp(2'd1, 3, db);
    watch(0, 1'b0, 2'd0, 0, '0);
    checks++; if (m_lat !== 36 || m_tms_err + m_tdi_err + m_tck_err !== 0)
      $display("FAIL b2b_second: got lat %0d wave_err %0d want 36 0", m_lat, m_tms_err + m_tdi_err + m_tck_err); else passed++;
    checks++; if (rsp_data0 !== (db & 40'h7)) $display("FAIL b2b_rsp_second: got %h want %h", rsp_data0, db & 40'h7); else passed++;
  endtask

  task automatic test_reset_mid;
    int bad;
    tdo_mode[0] = 2'd2;
    present(0, 2'd2, 8, 40'h5A);
    @(posedge clk);
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    repeat (19) @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++; if ({tck0, tms0, cmd_ready0, rsp_valid0, busy0} !== 5'b01100)
      $display("FAIL midrst_immediate: got %b want 01100", {tck0, tms0, cmd_ready0, rsp_valid0, busy0}); else passed++;
    @(negedge clk);
    checks++; if ({tck0, tms0, cmd_ready0, rsp_valid0} !== 4'b0110 || rsp_data0 !== '0)
      $display("FAIL midrst_next_clk: got %b rsp %h want 0110 0", {tck0, tms0, cmd_ready0, rsp_valid0}, rsp_data0); else passed++;
    rstn = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid0 || tck0 || !cmd_ready0) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL midrst_quiet: got %0d active cycles want 0", bad); else passed++;
    build_exp(2'd0, 0, '0);
    present(0, 2'd0, 0, '0);
    watch(0, 1'b0, 2'd0, 0, '0);
    checks++; if (m_lat !== 24 || m_tms_err !== 0)
      $display("FAIL midrst_recover: got lat %0d tms_err %0d want 24 0", m_lat, m_tms_err); else passed++;
  endtask

  initial begin
    rstn = 1'b0;
    cmd_valid = '0;
    tdo_rnd = '0;
    for (int i = 0; i < 2; i++) begin
      cmd_op[i] = '0; cmd_len[i] = '0; cmd_data[i] = '0; tdo_mode[i] = '0;
    end
    test_reset;
    test_reset_cmd;
    test_shift_dr;
    test_shift_ir;
    test_long_dr;
    test_len_edges;
    test_random;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
